ps2_frame_receiver: RTL

//   Front stage of the keyboard path: turns raw PS/2 clock/data lines into checked 8-bit scan-code bytes.
//   Its output feeds the scan-code decoder that tracks make/break, key_down[] and last_change.

---
 rtl/ps2_frame_receiver_pkg.sv | 21 ++
 rtl/ps2_frame_receiver_sync_filter.sv | 41 ++++
 rtl/ps2_frame_receiver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ps2_frame_receiver_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encodings, frame length and default timing.
// Used by the clock filter and the frame receiver.
package ps2_frame_receiver_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    localparam int PS2_FRAME_BITS     = 11;
    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 200000;

    // Odd parity: data plus parity bit must contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_frame_receiver_sync_filter.sv
// 2-flop synchroniser plus debounce for the raw PS/2 clock.
// filt_o follows the synchronised line FILTER_LEN cycles after it settles; shorter pulses are dropped.
module ps2_sync_filter
    import ps2_frame_receiver_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            // Count consecutive samples disagreeing with the current output.
            if (sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q[1];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: 11-bit frames into checked bytes with parity/stop/timeout errors.
// rx_valid/rx_err pulse in the cycle after the stop-bit event; no backpressure, the consumer must take each pulse.
module ps2_frame_receiver
    import ps2_frame_receiver_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic                  fclk;
    logic [1:0]            dsync_q;
    logic [FILTER_LEN-1:0] ddly_q;
    logic                  fclk_prev_q;
    logic                  bit_evt_q;
    logic                  bit_dat_q;

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic [7:0]            shreg_q;
    logic                  par_q;
    logic [TW-1:0]         tmo_q;
    logic [7:0]            rx_data_q;
    logic                  rx_valid_q;
    logic                  rx_err_q;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (ps2_clk),
        .filt_o (fclk)
    );

    // Data goes through the same synchroniser depth, then a FILTER_LEN delay so it
    // lines up with the debounced clock edge it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dsync_q     <= 2'b11;
            ddly_q      <= '1;
            fclk_prev_q <= 1'b1;
            bit_evt_q   <= 1'b0;
            bit_dat_q   <= 1'b1;
        end else begin
            dsync_q     <= {dsync_q[0], ps2_data};
            ddly_q      <= FILTER_LEN'({ddly_q, dsync_q[1]});
            fclk_prev_q <= fclk;
            bit_evt_q   <= fclk_prev_q & ~fclk;
            bit_dat_q   <= ddly_q[FILTER_LEN-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;

            // A bit event always beats the timeout; it only fires on a quiet cycle.
            if (state_q == S_IDLE || bit_evt_q) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
                tmo_q    <= '0;
                rx_err_q <= 1'b1;
                state_q  <= S_IDLE;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (bit_evt_q) begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (!bit_dat_q) state_q <= S_DATA;
                    end
                    S_DATA: begin
                        shreg_q <= {bit_dat_q, shreg_q[7:1]};
                        if (cnt_q == 3'd7) state_q <= S_PARITY;
                        else               cnt_q   <= cnt_q + 3'd1;
                    end
                    S_PARITY: begin
                        par_q   <= bit_dat_q;
                        state_q <= S_STOP;
                    end
                    S_STOP: begin
                        if (bit_dat_q && parity_ok(shreg_q, par_q)) begin
                            rx_data_q  <= shreg_q;
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign busy     = (state_q != S_IDLE);

endmodule
